// File: rtl/regfile_layer_cfg.sv
// Layer-configuration register bank for the NL/conv/pool engines.
// Software writes shadow words. An accepted START copies every shadow word
// into the active copy that drives the engine. The bank also tracks
// busy/done/err, raises a level irq and returns registered read data one
// cycle after rd_en. read_data is 0 whenever it is not valid, so the bus can
// OR it with the other regfile_* banks.

// One configuration word: the shadow copy is written by software and the
// active copy is loaded on START. rd_data is the shadow value when addr hits
// this word and 0 otherwise, ready to be ORed into the read mux.
module cfg_word #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 14,
  parameter logic [ADDR_W-1:0] ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] active,
  output logic [DATA_W-1:0] rd_data
);
  logic              hit;
  logic [DATA_W-1:0] shadow;

  assign hit     = (addr == ADDR);
  assign rd_data = hit ? shadow : '0;

  // Software write goes to the shadow; the active copy changes only on START.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en && hit) shadow <= write_data;
      if (load)         active <= shadow;
    end
  end
endmodule

module regfile_layer_cfg #(
  parameter int                ADDR_W    = 14,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h300,
  parameter int                NUM_RW    = 8,
  parameter int                NUM_RO    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     rd_valid,
  output logic [NUM_RW*DATA_W-1:0] cfg_active,
  input  logic [NUM_RO*DATA_W-1:0] status_in,
  output logic                     start_pulse,
  input  logic                     layer_done,
  output logic                     busy,
  output logic                     irq
);
  localparam logic [ADDR_W-1:0] CTRL_A = BASE_ADDR;
  localparam logic [ADDR_W-1:0] STAT_A = BASE_ADDR + ADDR_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  logic ctrl_wr, stat_wr, start_req, start_acc, start_rej;
  logic irq_en, done, err;
  logic [DATA_W-1:0] rd_mux;

  logic [NUM_RW-1:0][DATA_W-1:0] active;
  logic [NUM_RW-1:0][DATA_W-1:0] rw_rd;
  logic [NUM_RW:0][DATA_W-1:0]   rw_or;
  logic [NUM_RO:0][DATA_W-1:0]   ro_or;

  assign ctrl_wr   = wr_en && (addr == CTRL_A);
  assign stat_wr   = wr_en && (addr == STAT_A);
  assign start_req = ctrl_wr && write_data[0];
  // A completing layer frees the engine in the same cycle, so back-to-back
  // START is accepted when layer_done is high.
  assign start_acc = start_req && (!busy || layer_done);
  assign start_rej = start_req && busy && !layer_done;
  assign busy      = (state == RUN);

  // Shadow/active word array, one instance per configuration word.
  assign rw_or[0] = '0;
  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    cfg_word #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ADDR   (BASE_ADDR + ADDR_W'(2 + i))
    ) u_word (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .load       (start_acc),
      .addr       (addr),
      .write_data (write_data),
      .active     (active[i]),
      .rd_data    (rw_rd[i])
    );
    assign rw_or[i+1] = rw_or[i] | rw_rd[i];
  end

  // Engine status words are read live and never stored here.
  assign ro_or[0] = '0;
  for (genvar j = 0; j < NUM_RO; j++) begin : g_ro
    localparam logic [ADDR_W-1:0] RO_A = BASE_ADDR + ADDR_W'(2 + NUM_RW + j);
    assign ro_or[j+1] = ro_or[j] |
                        ((addr == RO_A) ? status_in[j*DATA_W +: DATA_W] : '0);
  end

  assign cfg_active = active;

  // IDLE/RUN state register; busy is the state itself.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: START enters RUN, layer_done leaves it unless a START lands too.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_acc) state_nxt = RUN;
      RUN:  if (layer_done && !start_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control/status flags; hardware set beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      start_pulse <= 1'b0;
      irq         <= 1'b0;
    end else begin
      start_pulse <= start_acc;
      if (ctrl_wr) irq_en <= write_data[1];
      done <= layer_done || (done && !(stat_wr && write_data[1]));
      err  <= start_rej  || (err  && !(stat_wr && write_data[2]));
      irq  <= done && irq_en;
    end
  end

  // Read mux over current state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = rw_or[NUM_RW] | ro_or[NUM_RO];
    if (addr == CTRL_A) rd_mux[1]   = irq_en;
    if (addr == STAT_A) rd_mux[2:0] = {err, done, busy};
  end

  // Registered read return; a reset in flight drops the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      read_data <= rd_en ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_regfile_layer_cfg.sv
// Bench for regfile_layer_cfg: an 8 RW / 4 RO bank and a 1 RW / 1 RO bank
// share the bus. Reads push their expected value on a queue; a negedge
// monitor pops and compares whenever the selected bank returns data.
module tb_regfile_layer_cfg;
  localparam logic [13:0] B = 14'h300;

  logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, layer_done = 1'b0;
  logic        phase_b = 1'b0;
  logic [13:0] addr = '0;
  logic [15:0] write_data = '0;
  logic [63:0] status_in_a = '0;
  logic [15:0] status_in_b = '0;

  logic [15:0]  rd_a, rd_b, mon_rd;
  logic         vld_a, vld_b, mon_vld;
  logic         sp_a, sp_b, busy_a, busy_b, irq_a, irq_b;
  logic [127:0] cfg_a;
  logic [15:0]  cfg_b;

  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  logic        exp_vld = 1'b0;

  regfile_layer_cfg #(.ADDR_W(14), .DATA_W(16), .BASE_ADDR(14'h300), .NUM_RW(8), .NUM_RO(4)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
    .read_data(rd_a), .rd_valid(vld_a), .cfg_active(cfg_a), .status_in(status_in_a),
    .start_pulse(sp_a), .layer_done(layer_done), .busy(busy_a), .irq(irq_a));

  regfile_layer_cfg #(.ADDR_W(14), .DATA_W(16), .BASE_ADDR(14'h300), .NUM_RW(1), .NUM_RO(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
    .read_data(rd_b), .rd_valid(vld_b), .cfg_active(cfg_b), .status_in(status_in_b),
    .start_pulse(sp_b), .layer_done(layer_done), .busy(busy_b), .irq(irq_b));

  always #5 clk = ~clk;

  assign mon_rd  = phase_b ? rd_b  : rd_a;
  assign mon_vld = phase_b ? vld_b : vld_a;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    addr = a; write_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input logic [15:0] e);
    addr = a; rd_en = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  // A read is due one edge after rd_en unless reset was sampled with it.
  always @(posedge clk) exp_vld <= rd_en && !rst;

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    chk("rd_valid", mon_vld, exp_vld);
    if (exp_vld) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("rd_data", mon_rd, exp_q.pop_front());
    end else begin
      chk("rd_idle", mon_rd, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state of the large bank
    tick(); tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_sp",   sp_a,   0);
    chk("rst_irq",  irq_a,  0);
    chk("rst_cfg",  cfg_a,  0);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) rd(14'(B + 14'(k)), 16'h0000);
    rd(B + 14'd200, 16'h0000);

    // Shadow writes do not reach the active copy
    wr(B + 14'd2, 16'h0040);
    wr(B + 14'd3, 16'h0020);
    rd(B + 14'd2, 16'h0040);
    rd(B + 14'd3, 16'h0020);
    chk("cfg_before_start", cfg_a, 0);

    // START with irq_en
    wr(B, 16'h0003);
    chk("start_pulse", sp_a, 1);
    chk("start_busy",  busy_a, 1);
    chk("start_w0",    cfg_a[15:0],  16'h0040);
    chk("start_w1",    cfg_a[31:16], 16'h0020);
    chk("start_w2",    cfg_a[47:32], 16'h0000);
    tick();
    chk("start_1cyc",  sp_a, 0);
    rd(B + 14'd1, 16'h0001);
    rd(B,         16'h0002);

    // START while busy is rejected and flags err
    wr(B + 14'd2, 16'h0080);
    wr(B, 16'h0003);
    chk("rej_sp",  sp_a, 0);
    chk("rej_w0",  cfg_a[15:0], 16'h0040);
    chk("rej_busy", busy_a, 1);
    rd(B + 14'd1, 16'h0005);

    // Completion: busy drops, done set, irq one cycle later
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    chk("done_busy", busy_a, 0);
    chk("done_irq_lat", irq_a, 0);
    tick();
    chk("done_irq", irq_a, 1);
    rd(B + 14'd1, 16'h0006);

    // W1C of done and err
    wr(B + 14'd1, 16'h0006);
    tick();
    chk("w1c_irq", irq_a, 0);
    rd(B + 14'd1, 16'h0000);

    // Back-to-back START in the same cycle as layer_done
    wr(B, 16'h0003);
    chk("b2b_busy0", busy_a, 1);
    wr(B + 14'd3, 16'h0077);
    addr = B; write_data = 16'h0003; wr_en = 1'b1; layer_done = 1'b1;
    tick();
    wr_en = 1'b0; layer_done = 1'b0;
    chk("b2b_sp",   sp_a, 1);
    chk("b2b_busy", busy_a, 1);
    chk("b2b_w0",   cfg_a[15:0],  16'h0080);
    chk("b2b_w1",   cfg_a[31:16], 16'h0077);
    rd(B + 14'd1, 16'h0003);

    // W1C of done loses to a same-cycle layer_done
    addr = B + 14'd1; write_data = 16'h0002; wr_en = 1'b1; layer_done = 1'b1;
    tick();
    wr_en = 1'b0; layer_done = 1'b0;
    rd(B + 14'd1, 16'h0002);

    // Same-cycle read and write return the old value
    addr = B + 14'd2; write_data = 16'h1234; wr_en = 1'b1; rd_en = 1'b1;
    exp_q.push_back(16'h0080);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rd(B + 14'd2, 16'h1234);
    chk("rw_cfg_keep", cfg_a[15:0], 16'h0080);

    // Live status words and the edges of the map
    status_in_a = 64'hD004_C003_B002_A001;
    rd(B + 14'd10, 16'hA001);
    rd(B + 14'd11, 16'hB002);
    rd(B + 14'd13, 16'hD004);
    rd(B + 14'd14, 16'h0000);
    rd(B - 14'd1,  16'h0000);
    wr(B + 14'd10, 16'hFFFF);
    rd(B + 14'd10, 16'hA001);

    // Reset while busy with a read in flight
    wr(B, 16'h0003);
    chk("pre_rst_busy", busy_a, 1);
    chk("pre_rst_irq",  irq_a, 1);
    addr = B + 14'd2; rd_en = 1'b1; rst = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_cfg",  cfg_a, 0);
    chk("mid_rst_irq",  irq_a, 0);
    chk("mid_rst_sp",   sp_a, 0);

    // Small bank: one RW word, one status word
    phase_b = 1'b1;
    tick();
    chk("b_rst_cfg",  cfg_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_irq",  irq_b, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) rd(14'(B + 14'(k)), 16'h0000);
    wr(B + 14'd2, 16'hABCD);
    rd(B + 14'd2, 16'hABCD);
    chk("b_cfg_hold", cfg_b, 0);
    status_in_b = 16'h5A5A;
    wr(B + 14'd3, 16'h1111);
    rd(B + 14'd3, 16'h5A5A);
    wr(B, 16'h0001);
    chk("b_sp",   sp_b, 1);
    chk("b_busy", busy_b, 1);
    chk("b_cfg",  cfg_b, 16'hABCD);
    rd(B + 14'd1, 16'h0001);
    addr = B + 14'd2; rd_en = 1'b1; rst = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("b_rst_busy2", busy_b, 0);
    chk("b_rst_cfg2",  cfg_b, 0);
    rst = 1'b0;
    tick(); tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
